key_event_fifo: RTL

Host-side consumer for the CPLD keypad scanner. Detects each new key press from the scanner's active-low interrupt and 4-bit key code, and queues codes in a small FIFO. Exposes a two-register strobe bus to the host processor and drives an active-low host interrupt while events are pending. Sits between the keypad scanner and the CPLD's host bus decoder.

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/key_event_fifo_sync_fifo.sv | 73 +++++++
 rtl/key_event_fifo.sv | 92 +++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared register map and size defaults for the keypad event FIFO.
package keypad_pkg;

  typedef enum logic {
    REG_DATA   = 1'b0,
    REG_STATUS = 1'b1
  } reg_addr_e;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int STAT_OVF_BIT    = 7;
  localparam int STAT_IRQ_EN_BIT = 6;
  localparam int STAT_COUNT_W    = 5;
  localparam int DATA_VALID_BIT  = 7;
  localparam int DATA_FLUSH_BIT  = 0;

  localparam int DEPTH_DEF  = 8;
  localparam int CODE_W_DEF = 4;

  function automatic logic [7:0] status_word(input logic ovf, input logic irq_en,
                                             input logic [STAT_COUNT_W-1:0] cnt);
    logic [7:0] w;
    w = 8'h00;
    w[STAT_OVF_BIT] = ovf;
    w[STAT_IRQ_EN_BIT] = irq_en;
    w[STAT_COUNT_W-1:0] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/key_event_fifo_sync_fifo.sv
// Small FIFO for key codes: storage, wrapping pointers, occupancy and overflow detect.
module sync_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [CODE_W-1:0]        din_i,
  output logic [CODE_W-1:0]        head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i & ~flush_i & (~full | do_pop);
  assign drop_o  = push_i & ~flush_i & full & ~do_pop;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == CW'(DEPTH - 1)) ? '0 : wr_ptr_q + CW'(1);
      if (do_pop)  rd_ptr_d = (rd_ptr_q == CW'(DEPTH - 1)) ? '0 : rd_ptr_q + CW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/key_event_fifo.sv
// Keypad press detector feeding a code FIFO, with a two-register host bus and active-low IRQ.
module key_event_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              key_int_n_i,
  input  logic [CODE_W-1:0] key_data_i,
  input  logic              rd_stb_i,
  input  logic              wr_stb_i,
  input  logic              addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o,
  output logic              irq_n_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              int_q, arm_q, cap_pend_q;
  logic              ovf_q, ovf_d;
  logic              irq_en_q, irq_en_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              irq_n_q;
  logic              fall, data_rd, flush, drop, empty;
  logic [CODE_W-1:0] head;
  logic [CW-1:0]     count;
  logic              unused_wdata;

  // arm_q keeps a key already held at reset release from looking like a fresh press.
  assign fall    = arm_q & int_q & ~key_int_n_i;
  assign data_rd = rd_stb_i & (addr_i == ADDR_DATA);
  assign flush   = wr_stb_i & (addr_i == ADDR_DATA) & wdata_i[DATA_FLUSH_BIT];
  assign unused_wdata = ^wdata_i[5:1];

  sync_fifo #(.DEPTH(DEPTH), .CODE_W(CODE_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cap_pend_q),
    .pop_i   (data_rd),
    .flush_i (flush),
    .din_i   (key_data_i),
    .head_o  (head),
    .count_o (count),
    .empty_o (empty),
    .drop_o  (drop)
  );

  always_comb begin
    rdata_d  = rdata_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    if (rd_stb_i) begin
      if (addr_i == ADDR_DATA) begin
        rdata_d = empty ? 8'h00 : (8'h80 | 8'(head));
      end else begin
        rdata_d = status_word(ovf_q, irq_en_q, STAT_COUNT_W'(count));
      end
    end
    if (wr_stb_i && addr_i == ADDR_STATUS) begin
      if (wdata_i[STAT_OVF_BIT]) ovf_d = 1'b0;
      irq_en_d = wdata_i[STAT_IRQ_EN_BIT];
    end
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      int_q      <= 1'b1;
      arm_q      <= 1'b0;
      cap_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      rdata_q    <= 8'h00;
      irq_n_q    <= 1'b1;
    end else begin
      int_q      <= key_int_n_i;
      arm_q      <= 1'b1;
      cap_pend_q <= fall;
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
      rdata_q    <= rdata_d;
      irq_n_q    <= ~(irq_en_q & (count != '0));
    end
  end

  assign rdata_o = rdata_q;
  assign irq_n_o = irq_n_q;

endmodule
